// File: rtl/wb_arb_pkg.sv
// Shared widths, result record and flat-slice helper for the wakeup bus arbiter.
package wb_arb_pkg;

    localparam int TAG_W  = 6;
    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] val;
    } wb_result_t;

    function automatic int flat_off(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/wakeup_bus_arbiter_rr_select.sv
// Round-robin multi-grant selector: hands the first NUM_BUS set request bits,
// scanning upward from start, to buses 0..NUM_BUS-1 in scan order.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int NUM_BUS = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [PTR_W-1:0]                start,
    output logic [NUM_BUS-1:0][NUM_REQ-1:0] grant,
    output logic [NUM_BUS-1:0]              found
);

    logic [PTR_W-1:0] idx_s;
    logic             hit_s;
    int               taken_s;

    // Scan from start; each hit goes to the bus numbered by how many were already taken.
    always_comb begin
        grant   = '0;
        found   = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        taken_s = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx_s = PTR_W'((int'(start) + j) % NUM_REQ);
            hit_s = req[idx_s] && (taken_s < NUM_BUS);
            for (int k = 0; k < NUM_BUS; k++) begin
                grant[k][idx_s] = grant[k][idx_s] | (hit_s && (taken_s == k));
                found[k]        = found[k] | (hit_s && (taken_s == k));
            end
            taken_s = taken_s + int'(hit_s);
        end
    end

endmodule

// File: rtl/wakeup_bus_arbiter.sv
// Result/wakeup broadcast arbiter: one holding slot per producer, round-robin onto
// NUM_BUS registered buses. Define WB_ARB_STATS_EN to add per-producer stall counters.
module wakeup_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_BUS = 2,
    parameter int TAG_W   = 6,
    parameter int ROB_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob,
    input  logic [NUM_REQ*DATA_W-1:0] req_val,
    output logic [NUM_BUS-1:0]        bus_valid,
    output logic [NUM_BUS*TAG_W-1:0]  bus_tag,
    output logic [NUM_BUS*ROB_W-1:0]  bus_rob,
    output logic [NUM_BUS*DATA_W-1:0] bus_val
`ifdef WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stall_cnt
`endif
);

    import wb_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ROB_W-1:0]  rob;
        logic [DATA_W-1:0] val;
    } slot_t;

    logic [NUM_REQ-1:0]              held_r;
    slot_t                           slot_r [NUM_REQ];
    logic [PTR_W-1:0]                rr_ptr_r;
    logic [NUM_BUS-1:0][NUM_REQ-1:0] grant_s;
    logic [NUM_BUS-1:0]              found_s;
    logic [NUM_REQ-1:0]              granted_s;
    logic [NUM_REQ-1:0]              accept_s;
    slot_t                           bus_nxt_s [NUM_BUS];
    logic [PTR_W-1:0]                ptr_nxt_s;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .NUM_BUS (NUM_BUS),
        .PTR_W   (PTR_W)
    ) u_rr_select (
        .req   (held_r),
        .start (rr_ptr_r),
        .grant (grant_s),
        .found (found_s)
    );

    // Collapse per-bus grants into per-slot grants, bus payloads and the next pointer.
    always_comb begin
        granted_s = '0;
        ptr_nxt_s = rr_ptr_r;
        for (int k = 0; k < NUM_BUS; k++) begin
            bus_nxt_s[k] = slot_t'('0);
            for (int i = 0; i < NUM_REQ; i++) begin
                granted_s[i] = granted_s[i] | grant_s[k][i];
                bus_nxt_s[k] = slot_t'(bus_nxt_s[k] | (grant_s[k][i] ? slot_r[i] : slot_t'('0)));
                ptr_nxt_s    = grant_s[k][i] ? PTR_W'((i + 1) % NUM_REQ) : ptr_nxt_s;
            end
        end
    end

    assign req_ready = ~held_r | granted_s;
    assign accept_s  = req_valid & req_ready;

    // Holding slots: a capture wins over a grant, so a granted slot can reload in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_r <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_r[i] <= slot_t'('0);
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept_s[i]) begin
                    held_r[i]     <= 1'b1;
                    slot_r[i].tag <= req_tag[flat_off(i, TAG_W) +: TAG_W];
                    slot_r[i].rob <= req_rob[flat_off(i, ROB_W) +: ROB_W];
                    slot_r[i].val <= req_val[flat_off(i, DATA_W) +: DATA_W];
                end else if (granted_s[i]) begin
                    held_r[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer and registered broadcast buses; idle buses keep their last payload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r  <= '0;
            bus_valid <= '0;
            bus_tag   <= '0;
            bus_rob   <= '0;
            bus_val   <= '0;
        end else begin
            rr_ptr_r <= ptr_nxt_s;
            for (int k = 0; k < NUM_BUS; k++) begin
                bus_valid[k] <= found_s[k];
                if (found_s[k]) begin
                    bus_tag[flat_off(k, TAG_W) +: TAG_W]   <= bus_nxt_s[k].tag;
                    bus_rob[flat_off(k, ROB_W) +: ROB_W]   <= bus_nxt_s[k].rob;
                    bus_val[flat_off(k, DATA_W) +: DATA_W] <= bus_nxt_s[k].val;
                end
            end
        end
    end

`ifdef WB_ARB_STATS_EN
    // Saturating count of cycles each slot waited while holding a result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (held_r[i] && !granted_s[i] && (stall_cnt[flat_off(i, 16) +: 16] != 16'hFFFF)) begin
                    stall_cnt[flat_off(i, 16) +: 16] <= stall_cnt[flat_off(i, 16) +: 16] + 16'd1;
                end
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_wakeup_bus_arbiter.sv
// Self-checking bench for wakeup_bus_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_wakeup_bus_arbiter;

    import wb_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int NUM_BUS = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*ROB_W-1:0]  req_rob;
    logic [NUM_REQ*DATA_W-1:0] req_val;
    logic [NUM_BUS-1:0]        bus_valid;
    logic [NUM_BUS*TAG_W-1:0]  bus_tag;
    logic [NUM_BUS*ROB_W-1:0]  bus_rob;
    logic [NUM_BUS*DATA_W-1:0] bus_val;
`ifdef WB_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]     stall_cnt;
`endif

    wakeup_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_BUS (NUM_BUS),
        .TAG_W   (TAG_W),
        .ROB_W   (ROB_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_rob   (req_rob),
        .req_val   (req_val),
        .bus_valid (bus_valid),
        .bus_tag   (bus_tag),
        .bus_rob   (bus_rob),
        .bus_val   (bus_val)
`ifdef WB_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit         m_held  [NUM_REQ];
    wb_result_t m_slot  [NUM_REQ];
    int         m_ptr;
    bit         m_bv    [NUM_BUS];
    wb_result_t m_bus   [NUM_BUS];
    int         m_stall [NUM_REQ];

    // Producer-side drive state
    bit         drv_v    [NUM_REQ];
    wb_result_t drv_p    [NUM_REQ];
    bit         last_acc [NUM_REQ];

    function automatic wb_result_t rand_result();
        wb_result_t r;
        r.tag = TAG_W'($urandom);
        r.rob = ROB_W'($urandom);
        r.val = DATA_W'($urandom);
        return r;
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_held[i]   = 1'b0;
            m_slot[i]   = '0;
            m_stall[i]  = 0;
            drv_v[i]    = 1'b0;
            drv_p[i]    = '0;
            last_acc[i] = 1'b1;
        end
        for (int k = 0; k < NUM_BUS; k++) begin
            m_bv[k]  = 1'b0;
            m_bus[k] = '0;
        end
    endfunction

    // One clock cycle: drive, check ready, clock, advance model, check buses.
    task automatic step();
        int                        g [$];
        bit                        gr [NUM_REQ];
        logic [NUM_REQ-1:0]        e_rdy;
        logic [NUM_BUS-1:0]        e_bv;
        logic [NUM_BUS*TAG_W-1:0]  e_tag;
        logic [NUM_BUS*ROB_W-1:0]  e_rob;
        logic [NUM_BUS*DATA_W-1:0] e_val;
        logic [NUM_REQ*16-1:0]     e_stall;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]                  = drv_v[i];
            req_tag[i*TAG_W +: TAG_W]     = drv_p[i].tag;
            req_rob[i*ROB_W +: ROB_W]     = drv_p[i].rob;
            req_val[i*DATA_W +: DATA_W]   = drv_p[i].val;
            gr[i]                         = 1'b0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            int i;
            i = (m_ptr + j) % NUM_REQ;
            if (m_held[i] && g.size() < NUM_BUS) g.push_back(i);
        end
        foreach (g[n]) gr[g[n]] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) e_rdy[i] = !m_held[i] || gr[i];
        #1;
        chk_eq("req_ready", req_ready, e_rdy);
        @(posedge clk);
        for (int k = 0; k < NUM_BUS; k++) begin
            if (k < g.size()) begin
                m_bv[k]  = 1'b1;
                m_bus[k] = m_slot[g[k]];
            end else begin
                m_bv[k] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_held[i] && !gr[i] && m_stall[i] < 65535) m_stall[i]++;
            last_acc[i] = drv_v[i] && e_rdy[i];
            if (last_acc[i]) begin
                m_slot[i] = drv_p[i];
                m_held[i] = 1'b1;
            end else if (gr[i]) begin
                m_held[i] = 1'b0;
            end
        end
        if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NUM_REQ;
        #1;
        for (int k = 0; k < NUM_BUS; k++) begin
            e_bv[k]                     = m_bv[k];
            e_tag[k*TAG_W +: TAG_W]     = m_bus[k].tag;
            e_rob[k*ROB_W +: ROB_W]     = m_bus[k].rob;
            e_val[k*DATA_W +: DATA_W]   = m_bus[k].val;
        end
        for (int i = 0; i < NUM_REQ; i++) e_stall[i*16 +: 16] = 16'(m_stall[i]);
        chk_eq("bus_valid", bus_valid, e_bv);
        chk_eq("bus_tag", bus_tag, e_tag);
        chk_eq("bus_rob", bus_rob, e_rob);
        chk_eq("bus_val", bus_val, e_val);
`ifdef WB_ARB_STATS_EN
        chk_eq("stall_cnt", stall_cnt, e_stall);
`else
        e_stall = '0;
`endif
        @(negedge clk);
    endtask

    // Asynchronous reset applied between clock edges (called at a negedge).
    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        #1;
        model_reset();
        chk_eq("rst_bus_valid", bus_valid, 64'd0);
        chk_eq("rst_bus_tag", bus_tag, 64'd0);
        chk_eq("rst_bus_val", bus_val, 64'd0);
        #1;
        reset = 1'b0;
        #1;
        chk_eq("rst_ready", req_ready, 64'hF);
        @(negedge clk);
    endtask

    // Keep a stalled offer stable; otherwise pick new traffic with the given valid odds.
    task automatic drive_random(input int pct);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!(drv_v[i] && !last_acc[i])) begin
                drv_v[i] = ($urandom_range(0, 99) < pct);
                drv_p[i] = rand_result();
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_tag   = '0;
        req_rob   = '0;
        req_val   = '0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single result on producer 0
        drv_v[0]     = 1'b1;
        drv_p[0].tag = 6'd5;
        drv_p[0].rob = 6'd3;
        drv_p[0].val = 32'hDEADBEEF;
        step();
        chk_eq("t1_latency", bus_valid, 64'd0);
        drv_v[0] = 1'b0;
        step();
        chk_eq("t1_valid", bus_valid, 64'd1);
        chk_eq("t1_tag", bus_tag[5:0], 64'd5);
        chk_eq("t1_rob", bus_rob[5:0], 64'd3);
        chk_eq("t1_val", bus_val[31:0], 64'hDEADBEEF);
        step();
        chk_eq("t1_idle", bus_valid, 64'd0);

        // Four simultaneous results from pointer 0
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_v[i]     = 1'b1;
            drv_p[i]     = rand_result();
            drv_p[i].tag = TAG_W'(10 + i);
        end
        step();
        for (int i = 0; i < NUM_REQ; i++) drv_v[i] = 1'b0;
        #1;
        chk_eq("t2_ready", req_ready, 64'h3);
        #1;
        step();
        chk_eq("t2_first_pair", bus_tag, {52'd0, 6'd11, 6'd10});
        step();
        chk_eq("t2_second_pair", bus_tag, {52'd0, 6'd13, 6'd12});
        chk_eq("t2_second_valid", bus_valid, 64'h3);
        step();
        chk_eq("t2_drained", bus_valid, 64'd0);

        // Streaming on producer 0
        apply_reset();
        for (int t = 1; t <= 10; t++) begin
            drv_v[0]     = 1'b1;
            drv_p[0]     = rand_result();
            drv_p[0].tag = TAG_W'(t);
            step();
            chk_eq("t3_ready0", req_ready[0], 64'd1);
            if (t >= 2) begin
                chk_eq("t3_bus0_valid", bus_valid[0], 64'd1);
                chk_eq("t3_bus0_tag", bus_tag[5:0], 64'(t - 1));
            end
        end

        // Four-way contention: grant pairs alternate {0,1},{2,3}
        apply_reset();
        for (int s = 1; s <= 9; s++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(drv_v[i] && !last_acc[i])) begin
                    drv_v[i]     = 1'b1;
                    drv_p[i]     = rand_result();
                    drv_p[i].rob = ROB_W'(i);
                end
            end
            step();
`ifdef WB_ARB_STATS_EN
            if (s == 2) chk_eq("t6_stall", stall_cnt, {16'd1, 16'd1, 16'd0, 16'd0});
`endif
            if (s >= 2) begin
                chk_eq("t4_both_valid", bus_valid, 64'h3);
                chk_eq("t4_pair", bus_rob, (s % 2 == 0) ? {52'd0, 6'd1, 6'd0} : {52'd0, 6'd3, 6'd2});
            end
        end

        // Reset while every slot is held and both buses are busy
        chk_eq("t5_pre_valid", bus_valid, 64'h3);
        apply_reset();
        step();
        chk_eq("t5_no_stale", bus_valid, 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive_random((n < 200) ? 70 : 30);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
